// File: rtl/rr_mem_read_arbiter.sv
// rr_mem_read_arbiter
// Round-robin arbiter sharing one memory_block read port among NUM_REQ
// requesters. Each issued read carries a requester tag through the fixed
// memory latency; returned data is queued with its tag in a response FIFO
// and delivered in issue order. A credit counter (in-flight + buffered)
// stops issuing before the FIFO could overflow.
// Optional build macro: RR_ARB_STATS_EN adds issue / credit-stall counters.

module rr_mem_read_arbiter_checker #(
    parameter int DUMMY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic full
);
    // Credits must make a push into a full FIFO impossible
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full)) else $error("rr_mem_read_arbiter: push into full response FIFO");
        end
    end
endmodule

module rr_mem_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDRW       = 9,
    parameter int DATAW       = 8,
    parameter int MEM_LATENCY = 2,
    parameter int RSP_DEPTH   = 8,
    parameter int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ADDRW-1:0] req_addr,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [ADDRW-1:0]         mem_raddr,
    input  logic [DATAW-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [DATAW-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]       rsp_ready
`ifdef RR_ARB_STATS_EN
    ,
    output logic [31:0]              stat_issues,
    output logic [31:0]              stat_credit_stalls
`endif
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic [IDW-1:0]   ptr_r;
    logic [CW-1:0]    credit_r;
    logic [ADDRW-1:0] raddr_r;

    logic [MEM_LATENCY-1:0] tag_valid_r;
    logic [IDW-1:0]         tag_id_r [MEM_LATENCY];

    logic [IDW-1:0]   fifo_id_r   [RSP_DEPTH];
    logic [DATAW-1:0] fifo_data_r [RSP_DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;

    logic             found_s;
    logic             grant_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic [IDW-1:0]   sel_s;
    logic [IDW-1:0]   cand_s;
    logic [IDW-1:0]   head_id_s;

    // Advance a FIFO pointer, wrapping at RSP_DEPTH (need not be a power of two)
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(RSP_DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // Round-robin search starting one past the last granted requester
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        cand_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = IDW'((int'(ptr_r) + k) % NUM_REQ);
            if (!found_s && req_valid[cand_s]) begin
                found_s = 1'b1;
                sel_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant only with a free credit; reset suppresses grants
    assign grant_s     = found_s && (credit_r < DEPTH_C) && !rst;
    assign head_id_s   = fifo_id_r[head_r];
    assign push_s      = tag_valid_r[MEM_LATENCY-1];
    assign pop_s       = (count_r != '0) && rsp_ready[head_id_s];
    assign fifo_full_s = (count_r == DEPTH_C);

    // Grant vector and memory address; address holds when nothing is issued
    always_comb begin
        req_ready = '0;
        mem_raddr = raddr_r;
        if (grant_s) begin
            req_ready[sel_s] = 1'b1;
            mem_raddr        = req_addr[int'(sel_s)*ADDRW +: ADDRW];
        end else begin
            req_ready = '0;
        end
    end

    // Response head presentation; no bypass, so only stored entries are shown
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (count_r != '0) begin
            rsp_valid[head_id_s] = 1'b1;
            rsp_data             = fifo_data_r[head_r];
        end else begin
            rsp_valid = '0;
        end
    end

    // Round-robin pointer, last issued address and credit count
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r    <= IDW'(NUM_REQ - 1);
            raddr_r  <= '0;
            credit_r <= '0;
        end else begin
            if (grant_s) begin
                ptr_r   <= sel_s;
                raddr_r <= req_addr[int'(sel_s)*ADDRW +: ADDRW];
            end else begin
                ptr_r   <= ptr_r;
                raddr_r <= raddr_r;
            end
            case ({grant_s, pop_s})
                2'b10:   credit_r <= credit_r + CW'(1);
                2'b01:   credit_r <= credit_r - CW'(1);
                default: credit_r <= credit_r;
            endcase
        end
    end

    // Tag shift register tracking reads through the memory latency
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_r <= '0;
            for (int s = 0; s < MEM_LATENCY; s++) begin
                tag_id_r[s] <= '0;
            end
        end else begin
            tag_valid_r[0] <= grant_s;
            tag_id_r[0]    <= sel_s;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                tag_valid_r[s] <= tag_valid_r[s-1];
                tag_id_r[s]    <= tag_id_r[s-1];
            end
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                tail_r <= next_ptr(tail_r);
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= next_ptr(head_r);
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Response FIFO storage; validity is governed by the pointers alone
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_id_r[tail_r]   <= tag_id_r[MEM_LATENCY-1];
            fifo_data_r[tail_r] <= mem_rdata;
        end
    end

`ifdef RR_ARB_STATS_EN
    // Accepted-request and credit-stall counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issues        <= 32'd0;
            stat_credit_stalls <= 32'd0;
        end else begin
            if (grant_s) begin
                stat_issues <= stat_issues + 32'd1;
            end else begin
                stat_issues <= stat_issues;
            end
            if ((|req_valid) && !grant_s && (credit_r == DEPTH_C)) begin
                stat_credit_stalls <= stat_credit_stalls + 32'd1;
            end else begin
                stat_credit_stalls <= stat_credit_stalls;
            end
        end
    end
`endif

    rr_mem_read_arbiter_checker u_checker (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .full (fifo_full_s)
    );

endmodule
